// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: shares one RAM port between icache and dcache word requests.
// dcache has priority; a burst counter guarantees instruction fetch eventually wins.
module mem_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int MAX_DBURST = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              ram_err
);

  localparam logic [1:0] RAM_ACCESS = 2'b10;
  localparam logic [1:0] RAM_ERROR  = 2'b11;
  localparam int CNT_W = $clog2(MAX_DBURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DBURST);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DGNT = 2'b01,
    IGNT = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [CNT_W-1:0] r_count;
  logic             r_ramErr;
  logic             w_dReq;
  logic             w_dDone;
  logic             w_iDone;

  assign w_dReq  = dREN | dWEN;
  assign w_dDone = (r_state == DGNT) && w_dReq && (ramstate == RAM_ACCESS);
  assign w_iDone = (r_state == IGNT) && iREN && (ramstate == RAM_ACCESS);
  assign ram_err = r_ramErr;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Consecutive dcache wins are counted only while icache is actually waiting.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_count <= '0;
    end else if (w_iDone) begin
      r_count <= '0;
    end else if (w_dDone) begin
      if (!iREN) begin
        r_count <= '0;
      end else if (r_count != CNT_MAX) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_ramErr <= 1'b0;
    end else if ((r_state != IDLE) && (ramstate == RAM_ERROR)) begin
      r_ramErr <= 1'b1;
    end
  end

  always_comb begin
    w_nextState = r_state;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    iload       = '0;
    dload       = '0;
    iwait       = iREN;
    dwait       = w_dReq;
    case (r_state)
      IDLE: begin
        if (w_dReq) begin
          w_nextState = (iREN && (r_count == CNT_MAX)) ? IGNT : DGNT;
        end else if (iREN) begin
          w_nextState = IGNT;
        end
      end
      DGNT: begin
        if (!w_dReq) begin
          w_nextState = IDLE;
        end else begin
          ramaddr  = daddr;
          ramstore = dstore;
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          if (ramstate == RAM_ACCESS) begin
            dwait       = 1'b0;
            dload       = dWEN ? '0 : ramload;
            w_nextState = IDLE;
          end
        end
      end
      IGNT: begin
        if (!iREN) begin
          w_nextState = IDLE;
        end else begin
          ramaddr = iaddr;
          ramREN  = 1'b1;
          if (ramstate == RAM_ACCESS) begin
            iwait       = 1'b0;
            iload       = ramload;
            w_nextState = IDLE;
          end
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then random
// traffic compared every cycle against an ownership-level model of the arbiter.
module tb_mem_arbiter;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int MAX_DBURST = 4;
  localparam logic [1:0] FREE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] ACCESS = 2'b10;
  localparam logic [1:0] ERROR  = 2'b11;

  logic              CLK = 1'b0;
  logic              nRST;
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              iwait;
  logic [DATA_W-1:0] iload;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              dwait;
  logic [DATA_W-1:0] dload;
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  logic [1:0]        ramstate;
  logic              ram_err;

  int checks   = 0;
  int failures = 0;
  bit modelValid = 0;

  // Model: who currently owns the RAM (0 nobody, 1 dcache, 2 icache) and how many
  // dcache accesses in a row have finished while icache was kept waiting.
  int mOwner = 0;
  int mBurst = 0;
  bit mErr   = 0;

  mem_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_DBURST(MAX_DBURST)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .ram_err(ram_err)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic ir, input logic [ADDR_W-1:0] ia,
                               input logic dr, input logic dw, input logic [ADDR_W-1:0] da,
                               input logic [DATA_W-1:0] ds, input logic [1:0] rs,
                               input logic [DATA_W-1:0] rl);
    nRST = rst; iREN = ir; iaddr = ia; dREN = dr; dWEN = dw;
    daddr = da; dstore = ds; ramstate = rs; ramload = rl;
  endtask

  task automatic nextCycle();
    @(posedge CLK);
    #1;
  endtask

  // Ownership changes at each clock edge from the rules of the arbiter.
  always @(posedge CLK) begin
    bit dReq;
    dReq = dREN || dWEN;
    if (!nRST) begin
      mOwner = 0; mBurst = 0; mErr = 0; modelValid = 1;
    end else begin
      if (mOwner != 0 && ramstate == ERROR) mErr = 1;
      if (mOwner == 0) begin
        if (dReq) mOwner = (iREN && mBurst == MAX_DBURST) ? 2 : 1;
        else if (iREN) mOwner = 2;
      end else if (mOwner == 1) begin
        if (!dReq) mOwner = 0;
        else if (ramstate == ACCESS) begin
          mOwner = 0;
          mBurst = iREN ? ((mBurst < MAX_DBURST) ? mBurst + 1 : MAX_DBURST) : 0;
        end
      end else begin
        if (!iREN) mOwner = 0;
        else if (ramstate == ACCESS) begin
          mOwner = 0;
          mBurst = 0;
        end
      end
    end
  end

  // Every cycle, outputs must follow from the current owner and the live inputs.
  always @(negedge CLK) begin
    if (modelValid) begin
      logic eRen, eWen, eIwait, eDwait;
      logic [ADDR_W-1:0] eAddr;
      logic [DATA_W-1:0] eStore, eIload, eDload;
      eRen = 0; eWen = 0; eAddr = 0; eStore = 0; eIload = 0; eDload = 0;
      eIwait = iREN; eDwait = dREN || dWEN;
      if (mOwner == 1 && (dREN || dWEN)) begin
        eAddr = daddr; eStore = dstore; eWen = dWEN; eRen = dREN && !dWEN;
        if (ramstate == ACCESS) begin
          eDwait = 0;
          eDload = dWEN ? 0 : ramload;
        end
      end else if (mOwner == 2 && iREN) begin
        eAddr = iaddr; eRen = 1;
        if (ramstate == ACCESS) begin
          eIwait = 0;
          eIload = ramload;
        end
      end
      checkOutput("m_ramREN", ramREN, eRen);
      checkOutput("m_ramWEN", ramWEN, eWen);
      checkOutput("m_ramaddr", ramaddr, eAddr);
      checkOutput("m_ramstore", ramstore, eStore);
      checkOutput("m_iwait", iwait, eIwait);
      checkOutput("m_dwait", dwait, eDwait);
      checkOutput("m_iload", iload, eIload);
      checkOutput("m_dload", dload, eDload);
      checkOutput("m_ram_err", ram_err, mErr);
    end
  end

  initial begin
    int renCycles;
    int nDone;
    logic [5:0] hist;

    applyStimulus(0, 0, 0, 0, 0, 0, 0, FREE, 0);
    nextCycle();
    nextCycle();

    // Reset state
    applyStimulus(1, 0, 0, 0, 0, 0, 0, FREE, 0);
    @(negedge CLK);
    checkOutput("rst_ramREN", ramREN, 0);
    checkOutput("rst_ram_err", ram_err, 0);
    checkOutput("rst_dwait", dwait, 0);
    nextCycle();

    // Single dcache read, ACCESS two cycles after grant
    applyStimulus(1, 0, 0, 1, 0, 32'h40, 0, FREE, 32'hDEADBEEF);
    @(negedge CLK);
    checkOutput("t1_idle_ramREN", ramREN, 0);
    checkOutput("t1_idle_dwait", dwait, 1);
    nextCycle();
    renCycles = 0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 0, 0, 1, 0, 32'h40, 0, (k == 2) ? ACCESS : BUSY, 32'hDEADBEEF);
      @(negedge CLK);
      if (ramREN) renCycles++;
      checkOutput("t1_ramaddr", ramaddr, 32'h40);
      checkOutput("t1_dwait", dwait, (k == 2) ? 0 : 1);
      if (k == 2) checkOutput("t1_dload", dload, 32'hDEADBEEF);
      nextCycle();
    end
    applyStimulus(1, 0, 0, 0, 0, 0, 0, FREE, 0);
    @(negedge CLK);
    checkOutput("t1_renCycles", renCycles, 3);
    checkOutput("t1_after_ramREN", ramREN, 0);
    nextCycle();

    // Simultaneous icache read and dcache write: dcache first
    applyStimulus(1, 1, 32'h100, 0, 1, 32'h80, 32'h12345678, FREE, 0);
    @(negedge CLK);
    checkOutput("t2_idle_iwait", iwait, 1);
    checkOutput("t2_idle_dwait", dwait, 1);
    nextCycle();
    applyStimulus(1, 1, 32'h100, 0, 1, 32'h80, 32'h12345678, ACCESS, 0);
    @(negedge CLK);
    checkOutput("t2_ramWEN", ramWEN, 1);
    checkOutput("t2_ramstore", ramstore, 32'h12345678);
    checkOutput("t2_ramaddr_d", ramaddr, 32'h80);
    checkOutput("t2_dwait", dwait, 0);
    checkOutput("t2_iwait_held", iwait, 1);
    nextCycle();
    applyStimulus(1, 1, 32'h100, 0, 0, 0, 0, BUSY, 0);
    @(negedge CLK);
    checkOutput("t2_gap_ramREN", ramREN, 0);
    checkOutput("t2_gap_iwait", iwait, 1);
    nextCycle();
    applyStimulus(1, 1, 32'h100, 0, 0, 0, 0, BUSY, 0);
    @(negedge CLK);
    checkOutput("t2_ramaddr_i", ramaddr, 32'h100);
    checkOutput("t2_iren", ramREN, 1);
    nextCycle();
    applyStimulus(1, 1, 32'h100, 0, 0, 0, 0, ACCESS, 32'hCAFE0001);
    @(negedge CLK);
    checkOutput("t2_iwait", iwait, 0);
    checkOutput("t2_iload", iload, 32'hCAFE0001);
    nextCycle();

    // Burst limit: icache held, dcache reissues back-to-back
    hist = 0;
    nDone = 0;
    for (int c = 0; c < 12; c++) begin
      applyStimulus(1, 1, 32'h200, 1, 0, 32'h300, 0, ACCESS, 32'h55);
      @(negedge CLK);
      if (!dwait) begin
        hist = {hist[4:0], 1'b0};
        nDone++;
      end else if (!iwait) begin
        hist = {hist[4:0], 1'b1};
        nDone++;
      end
      nextCycle();
    end
    checkOutput("t3_order", hist, 6'b000010);
    checkOutput("t3_completions", nDone, 6);

    // Read+write together with an ERROR cycle
    applyStimulus(1, 0, 0, 1, 1, 32'h44, 32'hA5A5, FREE, 32'h77);
    nextCycle();
    applyStimulus(1, 0, 0, 1, 1, 32'h44, 32'hA5A5, ERROR, 32'h77);
    @(negedge CLK);
    checkOutput("t4_ramWEN", ramWEN, 1);
    checkOutput("t4_ramREN", ramREN, 0);
    checkOutput("t4_err_before", ram_err, 0);
    checkOutput("t4_dwait_err", dwait, 1);
    nextCycle();
    applyStimulus(1, 0, 0, 1, 1, 32'h44, 32'hA5A5, ACCESS, 32'h77);
    @(negedge CLK);
    checkOutput("t4_err_set", ram_err, 1);
    checkOutput("t4_dwait", dwait, 0);
    checkOutput("t4_dload", dload, 0);
    nextCycle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, FREE, 0);
    @(negedge CLK);
    checkOutput("t4_err_sticky", ram_err, 1);
    nextCycle();

    // Reset during a busy dcache grant
    applyStimulus(1, 1, 32'h10, 1, 0, 32'h20, 0, BUSY, 0);
    nextCycle();
    applyStimulus(1, 1, 32'h10, 1, 0, 32'h20, 0, BUSY, 0);
    @(negedge CLK);
    checkOutput("t5_grant_ramREN", ramREN, 1);
    nextCycle();
    applyStimulus(0, 1, 32'h10, 1, 0, 32'h20, 0, BUSY, 0);
    nextCycle();
    applyStimulus(1, 1, 32'h10, 1, 0, 32'h20, 0, BUSY, 0);
    @(negedge CLK);
    checkOutput("t5_ramREN", ramREN, 0);
    checkOutput("t5_ramWEN", ramWEN, 0);
    checkOutput("t5_ram_err", ram_err, 0);
    checkOutput("t5_dwait", dwait, 1);
    checkOutput("t5_iwait", iwait, 1);
    nextCycle();

    // dcache request withdrawn mid-grant
    applyStimulus(1, 0, 0, 1, 0, 32'h60, 0, BUSY, 0);
    @(negedge CLK);
    checkOutput("t6_ramaddr", ramaddr, 32'h60);
    nextCycle();
    applyStimulus(1, 0, 0, 0, 0, 32'h60, 0, ACCESS, 32'hBAD0BAD0);
    @(negedge CLK);
    checkOutput("t6_dwait", dwait, 0);
    checkOutput("t6_ramREN", ramREN, 0);
    checkOutput("t6_dload", dload, 0);
    nextCycle();
    applyStimulus(1, 0, 0, 0, 0, 32'h60, 0, ACCESS, 32'hBAD0BAD0);
    @(negedge CLK);
    checkOutput("t6_idle_ramREN", ramREN, 0);
    nextCycle();

    // Random traffic, checked by the model every cycle
    for (int n = 0; n < 4000; n++) begin
      logic [1:0] rs;
      int pick;
      pick = $urandom_range(0, 15);
      rs = (pick < 5) ? FREE : (pick < 9) ? BUSY : (pick < 15) ? ACCESS : ERROR;
      applyStimulus(($urandom_range(0, 99) != 0),
                    ($urandom_range(0, 3) != 0), $urandom(),
                    ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0),
                    $urandom(), $urandom(), rs, $urandom());
      nextCycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
